// File: rtl/rx_fifo_pkg.sv
// Shared definitions for the UART receive FIFO: default sizes, the stored
// entry layout and the pointer width helper.
package rx_fifo_pkg;

  localparam int unsigned RX_FIFO_DEF_DEPTH      = 16;
  localparam int unsigned RX_FIFO_DEF_DATA_WIDTH = 8;

  // One stored entry: the error flag sits above the received byte
  typedef struct packed {
    logic                              err;
    logic [RX_FIFO_DEF_DATA_WIDTH-1:0] data;
  } rx_entry_t;

  // Address bits needed to index a DEPTH-entry array (at least one bit)
  function automatic int unsigned ptrWidth(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/rx_fifo_mem.sv
// Register-array storage for rx_fifo: synchronous write, combinational read.
// Contents are deliberately not reset; the pointer logic in the parent decides
// which locations hold live data.
module rx_fifo_mem
  import rx_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = RX_FIFO_DEF_DEPTH,
  parameter int unsigned WIDTH = RX_FIFO_DEF_DATA_WIDTH + 1
) (
  input  logic                       clk_i,
  input  logic                       wrEn_i,
  input  logic [ptrWidth(DEPTH)-1:0] wrAddr_i,
  input  logic [WIDTH-1:0]           wrData_i,
  input  logic [ptrWidth(DEPTH)-1:0] rdAddr_i,
  output logic [WIDTH-1:0]           rdData_o
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Store the incoming entry at the tail address on an accepted write
  always_ff @(posedge clk_i) begin
    if (wrEn_i) begin
      mem[wrAddr_i] <= wrData_i;
    end
  end

  assign rdData_o = mem[rdAddr_i];

endmodule

// File: rtl/rx_fifo.sv
// First-word-fall-through FIFO sitting behind the UART receiver. Each entry
// holds a received byte plus its parity/framing error flag. Occupancy and
// flags are registered; a sticky overflow flag records bytes lost while full.
// Build option: define RX_FIFO_ERR_DROP_EN to discard errored bytes instead
// of storing them (rd_err then reads constant 0).
module rx_fifo
  import rx_fifo_pkg::*;
#(
  parameter int unsigned DEPTH      = RX_FIFO_DEF_DEPTH,
  parameter int unsigned DATA_WIDTH = RX_FIFO_DEF_DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_strobe,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic                     wr_err,
  input  logic                     rd_en,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     rd_err,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     clr_overflow
);

  localparam int unsigned PW = ptrWidth(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned EW = DATA_WIDTH + 1;
  localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic          empty_q, empty_d;
  logic          full_q, full_d;
  logic          overflow_q, overflow_d;
  logic          armed_q;

  logic          strobeOk;
  logic          wrAccept;
  logic          rdAccept;
  logic          dropFull;
  logic [EW-1:0] wrEntry;
  logic [EW-1:0] rdEntry;

  // Errored bytes are either filtered out before the FIFO or stored with their flag
`ifdef RX_FIFO_ERR_DROP_EN
  assign strobeOk = wr_strobe & ~wr_err;
  assign wrEntry  = {1'b0, wr_data};
  assign rd_err   = 1'b0;
`else
  assign strobeOk = wr_strobe;
  assign wrEntry  = {wr_err, wr_data};
  assign rd_err   = rdEntry[DATA_WIDTH];
`endif

  assign rd_data = rdEntry[DATA_WIDTH-1:0];

  // A write while full is still taken if the head leaves in the same cycle
  assign rdAccept = armed_q & rd_en & ~empty_q;
  assign wrAccept = armed_q & strobeOk & (~full_q | rd_en);
  assign dropFull = armed_q & strobeOk & full_q & ~rd_en;

  // Blocks traffic on the first edge after reset release, since rst_n may have risen inside that cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q <= 1'b0;
    end else begin
      armed_q <= 1'b1;
    end
  end

  // Next pointers, occupancy and flags from the accepted write/pop this cycle
  always_comb begin
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (wrAccept) begin
      wrPtr_d = wrPtr_q + PW'(1);
    end
    if (rdAccept) begin
      rdPtr_d = rdPtr_q + PW'(1);
    end
    if (wrAccept && !rdAccept) begin
      count_d = count_q + CW'(1);
    end else if (rdAccept && !wrAccept) begin
      count_d = count_q - CW'(1);
    end
    if (dropFull) begin
      overflow_d = 1'b1;
    end else if (clr_overflow) begin
      overflow_d = 1'b0;
    end
    empty_d = (count_d == '0);
    full_d  = (count_d == COUNT_FULL);
  end

  // Pointer, occupancy and flag registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
    end
  end

  assign empty    = empty_q;
  assign full     = full_q;
  assign count    = count_q;
  assign overflow = overflow_q;

  rx_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_mem (
    .clk_i    (clk),
    .wrEn_i   (wrAccept),
    .wrAddr_i (wrPtr_q),
    .wrData_i (wrEntry),
    .rdAddr_i (rdPtr_q),
    .rdData_o (rdEntry)
  );

endmodule

// File: tb/tb_rx_fifo.sv
// Directed testbench for rx_fifo (default DEPTH=16, DATA_WIDTH=8).
// Honours RX_FIFO_ERR_DROP_EN so the same bench covers either build.
module tb_rx_fifo;

  logic       clk;
  logic       rst_n;
  logic       wr_strobe;
  logic [7:0] wr_data;
  logic       wr_err;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_err;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       overflow;
  logic       clr_overflow;

  int errors = 0;
  int checks = 0;

  rx_fifo dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_strobe    (wr_strobe),
    .wr_data      (wr_data),
    .wr_err       (wr_err),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_err       (rd_err),
    .empty        (empty),
    .full         (full),
    .count        (count),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  // 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance past the next rising edge; inputs change and outputs are sampled 1ns later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_strobe    = 1'b0;
    wr_data      = 8'h00;
    wr_err       = 1'b0;
    rd_en        = 1'b0;
    clr_overflow = 1'b0;
  endtask

  task automatic push(input logic [7:0] d);
    wr_strobe = 1'b1;
    wr_data   = d;
    wr_err    = 1'b0;
    tick();
    wr_strobe = 1'b0;
  endtask

  task automatic pop();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if (empty !== 1'b1 || full !== 1'b0 || count !== 5'd0 || overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags: got empty=%b full=%b count=%0d ovf=%b, expected 1 0 0 0",
               empty, full, count, overflow);
    end
    tick();
    // Release rst_n mid-cycle with a strobe pending: the next edge must ignore it
    wr_strobe = 1'b1;
    wr_data   = 8'h11;
    #2 rst_n = 1'b1;
    tick();
    checks++;
    if (empty !== 1'b1 || count !== 5'd0) begin
      errors++;
      $display("[TB] FAIL reset_first_edge: got empty=%b count=%0d, expected 1 0", empty, count);
    end
    tick();
    wr_strobe = 1'b0;
    checks++;
    if (empty !== 1'b0 || count !== 5'd1 || rd_data !== 8'h11) begin
      errors++;
      $display("[TB] FAIL reset_second_edge: got empty=%b count=%0d data=%h, expected 0 1 11",
               empty, count, rd_data);
    end
    pop();
  endtask

  task automatic test_single();
    push(8'hA5);
    checks++;
    if (empty !== 1'b0 || rd_data !== 8'hA5 || rd_err !== 1'b0 || count !== 5'd1) begin
      errors++;
      $display("[TB] FAIL single_write: got empty=%b data=%h err=%b count=%0d, expected 0 a5 0 1",
               empty, rd_data, rd_err, count);
    end
    pop();
    checks++;
    if (empty !== 1'b1 || count !== 5'd0) begin
      errors++;
      $display("[TB] FAIL single_pop: got empty=%b count=%0d, expected 1 0", empty, count);
    end
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < 16; i++) push(8'(i));
    checks++;
    if (full !== 1'b1 || count !== 5'd16 || overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL fill_full: got full=%b count=%0d ovf=%b, expected 1 16 0", full, count, overflow);
    end
    push(8'hFF);
    checks++;
    if (overflow !== 1'b1 || count !== 5'd16) begin
      errors++;
      $display("[TB] FAIL drop_sets_overflow: got ovf=%b count=%0d, expected 1 16", overflow, count);
    end
    // A clear coinciding with a new drop must leave overflow set
    wr_strobe = 1'b1;
    wr_data = 8'hEE;
    clr_overflow = 1'b1;
    tick();
    idle();
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("[TB] FAIL clr_vs_drop: got ovf=%b, expected 1", overflow);
    end
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clr_overflow: got ovf=%b, expected 0", overflow);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (rd_data !== 8'(i) || empty !== 1'b0) begin
        errors++;
        $display("[TB] FAIL fill_order[%0d]: got data=%h empty=%b, expected %h 0", i, rd_data, empty, 8'(i));
      end
      pop();
    end
    checks++;
    if (empty !== 1'b1 || count !== 5'd0) begin
      errors++;
      $display("[TB] FAIL fill_drained: got empty=%b count=%0d, expected 1 0", empty, count);
    end
  endtask

  task automatic test_full_pass();
    for (int i = 0; i < 16; i++) push(8'h10 + 8'(i));
    wr_strobe = 1'b1;
    wr_data   = 8'h55;
    rd_en     = 1'b1;
    tick();
    idle();
    checks++;
    if (count !== 5'd16 || overflow !== 1'b0 || full !== 1'b1 || rd_data !== 8'h11) begin
      errors++;
      $display("[TB] FAIL full_write_pop: got count=%0d ovf=%b full=%b data=%h, expected 16 0 1 11",
               count, overflow, full, rd_data);
    end
    for (int i = 1; i < 16; i++) pop();
    checks++;
    if (rd_data !== 8'h55 || count !== 5'd1) begin
      errors++;
      $display("[TB] FAIL full_last_entry: got data=%h count=%0d, expected 55 1", rd_data, count);
    end
    pop();
  endtask

  task automatic test_empty_pass();
    wr_strobe = 1'b1;
    wr_data   = 8'h3C;
    rd_en     = 1'b1;
    tick();
    idle();
    checks++;
    if (count !== 5'd1 || rd_data !== 8'h3C || empty !== 1'b0) begin
      errors++;
      $display("[TB] FAIL empty_write_read: got count=%0d data=%h empty=%b, expected 1 3c 0",
               count, rd_data, empty);
    end
    pop();
    pop();
    checks++;
    if (count !== 5'd0 || empty !== 1'b1) begin
      errors++;
      $display("[TB] FAIL read_on_empty: got count=%0d empty=%b, expected 0 1", count, empty);
    end
    // After an ignored empty read, the next write must land at the head
    push(8'h42);
    checks++;
    if (rd_data !== 8'h42 || count !== 5'd1) begin
      errors++;
      $display("[TB] FAIL after_empty_read: got data=%h count=%0d, expected 42 1", rd_data, count);
    end
    pop();
  endtask

  task automatic test_err_flag();
    wr_strobe = 1'b1;
    wr_data   = 8'h7E;
    wr_err    = 1'b1;
    tick();
    idle();
`ifdef RX_FIFO_ERR_DROP_EN
    checks++;
    if (empty !== 1'b1 || overflow !== 1'b0 || count !== 5'd0) begin
      errors++;
      $display("[TB] FAIL err_drop: got empty=%b ovf=%b count=%0d, expected 1 0 0", empty, overflow, count);
    end
`else
    checks++;
    if (rd_err !== 1'b1 || rd_data !== 8'h7E || empty !== 1'b0) begin
      errors++;
      $display("[TB] FAIL err_store: got err=%b data=%h empty=%b, expected 1 7e 0", rd_err, rd_data, empty);
    end
    pop();
`endif
  endtask

  task automatic test_back_to_back();
    logic [7:0] model[$];
    logic [7:0] head;
    // Reach 5 entries with overflow set, then reset in the middle of a strobe
    for (int i = 0; i < 16; i++) push(8'h20 + 8'(i));
    push(8'hFF);
    for (int i = 0; i < 11; i++) pop();
    checks++;
    if (count !== 5'd5 || overflow !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pre_reset: got count=%0d ovf=%b, expected 5 1", count, overflow);
    end
    wr_strobe = 1'b1;
    wr_data   = 8'hEE;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (empty !== 1'b1 || count !== 5'd0 || overflow !== 1'b0 || full !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_reset: got empty=%b count=%0d ovf=%b full=%b, expected 1 0 0 0",
               empty, count, overflow, full);
    end
    idle();
    tick();
    #2 rst_n = 1'b1;
    tick();
    // Keep three entries in flight, then push and pop together for 40 cycles
    for (int i = 0; i < 3; i++) begin
      push(8'hC0 + 8'(i));
      model.push_back(8'hC0 + 8'(i));
    end
    for (int k = 0; k < 40; k++) begin
      head = model.pop_front();
      checks++;
      if (rd_data !== head) begin
        errors++;
        $display("[TB] FAIL wrap_order[%0d]: got %h expected %h", k, rd_data, head);
      end
      wr_strobe = 1'b1;
      wr_data   = 8'h80 + 8'(k);
      rd_en     = 1'b1;
      model.push_back(8'h80 + 8'(k));
      tick();
    end
    idle();
    checks++;
    if (count !== 5'd3) begin
      errors++;
      $display("[TB] FAIL wrap_count: got %0d expected 3", count);
    end
    while (model.size() > 0) begin
      head = model.pop_front();
      checks++;
      if (rd_data !== head) begin
        errors++;
        $display("[TB] FAIL wrap_tail: got %h expected %h", rd_data, head);
      end
      pop();
    end
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("[TB] FAIL wrap_drained: got empty=%b expected 1", empty);
    end
  endtask

  // Run every scenario in order, then report
  initial begin
    test_reset();
    test_single();
    test_fill_overflow();
    test_full_pass();
    test_empty_pass();
    test_err_flag();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rx_fifo.md
RX_FIFO -- requirements
Module: rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of stored entries (power of two, 4..256).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, received byte width.
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port wr_strobe  input  1  one-cycle pulse from rx data_strobe; capture wr_data/wr_err.
REQ-006 SHALL have port wr_data  input  DATA_WIDTH  received byte from rx dout.
REQ-007 SHALL have port wr_err  input  1  rx_error (parity/framing) for the byte being strobed.
REQ-008 SHALL have port rd_en  input  1  consumer pop request; honoured only when empty=0.
REQ-009 SHALL have port rd_data  output  DATA_WIDTH  head entry byte, valid whenever empty=0 (first-word-fall-through).
REQ-010 SHALL have port rd_err  output  1  error flag of head entry.
REQ-011 SHALL have port empty  output  1  no entries stored.
REQ-012 SHALL have port full  output  1  DEPTH entries stored.
REQ-013 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-014 SHALL have port overflow  output  1  sticky: a strobed byte was lost because FIFO was full.
REQ-015 SHALL have port clr_overflow  input  1  synchronous clear of overflow.

Function
REQ-016 SHALL write {wr_err, wr_data} at tail on wr_strobe when full=0, or when full=1 and rd_en=1 in the same cycle.
REQ-017 SHALL pop head on rd_en when empty=0; rd_en while empty=1 SHALL be ignored with no pointer or count change.
REQ-018 SHALL update count/empty/full registered: a write into empty FIFO deasserts empty and presents rd_data on the next cycle (1-cycle latency).
REQ-019 SHALL, on simultaneous accepted write and pop, keep count unchanged and advance both pointers.
REQ-020 SHALL, on simultaneous wr_strobe and rd_en with empty=1, accept the write, ignore the read, count becomes 1.
REQ-021 SHALL wrap read and write pointers modulo DEPTH; count never exceeds DEPTH nor drops below 0.
REQ-022 SHALL drop a byte strobed while full=1 and rd_en=0, leave contents unchanged, and set overflow next cycle.
REQ-023 SHALL hold overflow until clr_overflow; clr_overflow and a new drop in the same cycle leave overflow=1.
REQ-024 SHALL treat rd_data/rd_err as don't-care while empty=1 but hold them stable while empty=0 and rd_en=0.

Reset
REQ-025 SHALL, while rst_n=0, force pointers=0, count=0, empty=1, full=0, overflow=0 asynchronously.
REQ-026 SHALL discard all stored entries on reset, including reset asserted mid-write or mid-read; storage array is not reset.
REQ-027 SHALL ignore wr_strobe and rd_en on the first clock edge after rst_n deasserts only if rst_n deasserted within that cycle; otherwise normal operation.

Configuration
REQ-028 SHALL, with RX_FIFO_ERR_DROP_EN defined, discard bytes strobed with wr_err=1 (never stored, do not set overflow) and rd_err SHALL be tied 0.
REQ-029 SHALL, with RX_FIFO_ERR_DROP_EN undefined, store errored bytes with flag and present it on rd_err.

Structure
REQ-030 SHALL place entry typedef {err, data}, DEPTH/DATA_WIDTH defaults and pointer-width function in package rx_fifo_pkg.
REQ-031 SHALL instantiate one sub-module rx_fifo_mem: DEPTH-entry register array, synchronous write, asynchronous read.
REQ-032 SHALL keep pointer, count and flag logic in rx_fifo itself.

Verification
REQ-033 Reset, strobe 0xA5 (err=0) -> next cycle empty=0, rd_data=0xA5, rd_err=0, count=1; rd_en -> empty=1, count=0.
REQ-034 Strobe 16 bytes 0x00..0x0F, no reads -> full=1, count=16; 17th strobe 0xFF -> overflow=1, pops return 0x00..0x0F in order.
REQ-035 Full FIFO, wr_strobe 0x55 with rd_en same cycle -> count stays 16, overflow=0, 0x55 read out last.
REQ-036 Empty FIFO, wr_strobe 0x3C with rd_en -> count=1, rd_data=0x3C; rd_en on empty -> count stays 0.
REQ-037 Strobe 0x7E with wr_err=1 -> without macro rd_err=1, rd_data=0x7E; with RX_FIFO_ERR_DROP_EN empty stays 1.
REQ-038 Fill 5 entries, pulse rst_n low mid-strobe -> empty=1, count=0, overflow=0 immediately; 40 push/pop wrap cycles keep data order.
